xkeypad: RTL and testbench

Decimal number entry block: the input-side counterpart of the 7-segment display driver. It scans a 4x4 matrix keypad and debounces key presses. It assembles up to three decimal digits plus a sign into an 11-bit two's-complement value, the same format the display consumes. Each committed value is presented on data_out together with a one-cycle valid strobe for the processor/bus side.

---
 rtl/xkeypad.sv | 189 ++++++++++++++++++
 tb/tb_xkeypad.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/xkeypad.sv
`default_nettype none
// ------------------------------------------------------------------------
// xkeypad: 4x4 matrix keypad scanner and debouncer. It assembles a signed
//          3-digit decimal entry and commits it as 11-bit two's complement.
// Rev 1.0
// ------------------------------------------------------------------------
module xkeypad #(
  parameter int SCAN_BITS  = 16,
  parameter int DEB_FRAMES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic [11:0] data_out
);

  localparam int              CNT_W      = $clog2(DEB_FRAMES + 1);
  localparam logic [CNT_W-1:0] c_deb     = CNT_W'(DEB_FRAMES);
  localparam logic [4:0]      c_code_none  = 5'h10;
  localparam logic [4:0]      c_code_multi = 5'h11;
  localparam logic [3:0]      c_sym_a    = 4'd10;
  localparam logic [3:0]      c_sym_star = 4'd14;
  localparam logic [3:0]      c_sym_hash = 4'd15;

  typedef enum logic [0:0] {ST_EMPTY = 1'b0, ST_ENTRY = 1'b1} state_t;

  logic [3:0]           col_s1_q, col_s2_q;
  logic [SCAN_BITS-1:0] dwell_q;
  logic [1:0]           idx_q;
  logic [1:0]           fn_q;
  logic [3:0]           fkey_q;
  logic [4:0]           cand_q, stable_q;
  logic [CNT_W-1:0]     cnt_q;

  state_t      state_q, state_d;
  logic [9:0]  acc_q, acc_d;
  logic [1:0]  ndig_q, ndig_d;
  logic        neg_q, neg_d;
  logic [10:0] val_q, val_d;
  logic        vld_q, vld_d;

  logic             w_last, w_frame_end, w_press;
  logic [3:0]       w_low;
  logic [2:0]       w_nsamp, w_sum;
  logic [1:0]       w_base_n, w_sum_sat, w_cpos;
  logic [3:0]       w_key;
  logic [4:0]       w_code, w_stable_d;
  logic [CNT_W-1:0] w_cnt_d;
  logic [3:0]       w_sym;

  assign row      = ~(4'b0001 << idx_q);
  assign data_out = {vld_q, val_q};

  // Frame accumulator: fn counts keys seen this frame (saturating at 2 = multi).
  always_comb begin
    w_last      = &dwell_q;
    w_frame_end = w_last && (idx_q == 2'd3);
    w_low       = ~col_s2_q;
    w_nsamp     = 3'(w_low[0]) + 3'(w_low[1]) + 3'(w_low[2]) + 3'(w_low[3]);
    case (w_low)
      4'b0010: w_cpos = 2'd1;
      4'b0100: w_cpos = 2'd2;
      4'b1000: w_cpos = 2'd3;
      default: w_cpos = 2'd0;
    endcase
    w_base_n  = (idx_q == 2'd0) ? 2'd0 : fn_q;
    w_sum     = {1'b0, w_base_n} + w_nsamp;
    w_sum_sat = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    w_key     = (w_nsamp == 3'd1) ? {idx_q, w_cpos} : fkey_q;
    if (w_sum_sat == 2'd0)      w_code = c_code_none;
    else if (w_sum_sat == 2'd1) w_code = {1'b0, w_key};
    else                        w_code = c_code_multi;
  end

  // A stable multi-key code blocks events until a clean all-released NONE.
  always_comb begin
    if (w_code == cand_q) w_cnt_d = (cnt_q == c_deb) ? cnt_q : cnt_q + CNT_W'(1);
    else                  w_cnt_d = CNT_W'(1);
    w_stable_d = (w_cnt_d == c_deb) ? w_code : stable_q;
    w_press    = w_frame_end && (stable_q == c_code_none) && !w_stable_d[4];
    case (w_stable_d[3:0])
      4'd0:    w_sym = 4'd1;
      4'd1:    w_sym = 4'd2;
      4'd2:    w_sym = 4'd3;
      4'd3:    w_sym = c_sym_a;
      4'd4:    w_sym = 4'd4;
      4'd5:    w_sym = 4'd5;
      4'd6:    w_sym = 4'd6;
      4'd7:    w_sym = 4'd11;
      4'd8:    w_sym = 4'd7;
      4'd9:    w_sym = 4'd8;
      4'd10:   w_sym = 4'd9;
      4'd11:   w_sym = 4'd12;
      4'd12:   w_sym = c_sym_star;
      4'd13:   w_sym = 4'd0;
      4'd14:   w_sym = c_sym_hash;
      default: w_sym = 4'd13;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_s1_q <= 4'hF;
      col_s2_q <= 4'hF;
      dwell_q  <= '0;
      idx_q    <= 2'd0;
      fn_q     <= 2'd0;
      fkey_q   <= 4'd0;
      cand_q   <= c_code_none;
      cnt_q    <= '0;
      stable_q <= c_code_none;
    end else begin
      col_s1_q <= col;
      col_s2_q <= col_s1_q;
      dwell_q  <= dwell_q + SCAN_BITS'(1);
      if (w_last) begin
        idx_q  <= idx_q + 2'd1;
        fn_q   <= w_sum_sat;
        fkey_q <= w_key;
      end
      if (w_frame_end) begin
        cand_q   <= w_code;
        cnt_q    <= w_cnt_d;
        stable_q <= w_stable_d;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ndig_d  = ndig_q;
    neg_d   = neg_q;
    val_d   = val_q;
    vld_d   = 1'b0;
    if (w_press && sel) begin
      if (w_sym <= 4'd9) begin
        if (ndig_q != 2'd3) begin
          state_d = ST_ENTRY;
          if (!(w_sym == 4'd0 && ndig_q == 2'd0)) begin
            acc_d  = acc_q * 10'd10 + {6'd0, w_sym};
            ndig_d = ndig_q + 2'd1;
          end
        end
      end else begin
        case (w_sym)
          c_sym_star: neg_d = ~neg_q;
          c_sym_a: begin
            state_d = ST_EMPTY;
            acc_d   = '0;
            ndig_d  = '0;
            neg_d   = 1'b0;
          end
          c_sym_hash: begin
            val_d   = neg_q ? (11'd0 - {1'b0, acc_q}) : {1'b0, acc_q};
            vld_d   = 1'b1;
            state_d = ST_EMPTY;
            acc_d   = '0;
            ndig_d  = '0;
            neg_d   = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      acc_q   <= '0;
      ndig_q  <= '0;
      neg_q   <= 1'b0;
      val_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ndig_q  <= ndig_d;
      neg_q   <= neg_d;
      val_q   <= val_d;
      vld_q   <= vld_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xkeypad.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_xkeypad: table-driven key-sequence bench for xkeypad.
// Rev 1.0
// ------------------------------------------------------------------------
module tb_xkeypad;

  localparam int SB   = 2;
  localparam int DF   = 2;
  localparam int HOLD = 80;
  localparam int REL  = 80;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b1;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [11:0] data_out;
  logic [15:0] keys = 16'h0;

  xkeypad #(.SCAN_BITS(SB), .DEB_FRAMES(DF)) dut (
    .clk(clk), .rst(rst), .sel(sel), .col(col), .row(row), .data_out(data_out)
  );

  always #5 clk = ~clk;

  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  int          pulses  = 0;
  int          doubles = 0;
  logic [10:0] last_val = 11'h0;
  logic        prev_v = 1'b0;

  always @(negedge clk) begin
    if (data_out[11]) begin
      pulses++;
      last_val = data_out[10:0];
      if (prev_v) doubles++;
    end
    prev_v = data_out[11];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int kpos(input byte ch);
    case (ch)
      "1": return 0;  "2": return 1;  "3": return 2;  "A": return 3;
      "4": return 4;  "5": return 5;  "6": return 6;  "B": return 7;
      "7": return 8;  "8": return 9;  "9": return 10; "C": return 11;
      "*": return 12; "0": return 13; "#": return 14; default: return 15;
    endcase
  endfunction

  task automatic press(input byte ch);
    keys = 16'h1 << kpos(ch);
    repeat (HOLD) @(negedge clk);
    keys = 16'h0;
    repeat (REL) @(negedge clk);
  endtask

  task automatic enter(input string s);
    for (int i = 0; i < s.len(); i++) press(s[i]);
  endtask

  // Commit a sequence and check one strobe carrying the expected value.
  task automatic commit(input string name, input string s, input logic [10:0] exp);
    int p0;
    p0 = pulses;
    enter(s);
    check({name, " pulses"}, pulses - p0, 1);
    check({name, " value"}, {21'd0, data_out[10:0]}, {21'd0, exp});
    check({name, " strobe value"}, {21'd0, last_val}, {21'd0, exp});
  endtask

  typedef struct {
    string       seq;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[10];
  int   p0;

  initial begin
    vecs[0] = '{"123#",  11'h07B};
    vecs[1] = '{"*45#",  11'h7D3};
    vecs[2] = '{"**7#",  11'h007};
    vecs[3] = '{"1234#", 11'h07B};
    vecs[4] = '{"009#",  11'h009};
    vecs[5] = '{"6A2#",  11'h002};
    vecs[6] = '{"999#",  11'h3E7};
    vecs[7] = '{"*999#", 11'h419};
    vecs[8] = '{"B5CD#", 11'h005};
    vecs[9] = '{"*#",    11'h000};

    repeat (3) @(negedge clk);
    check("reset row", {28'd0, row}, {28'd0, 4'b1110});
    check("reset data_out", {20'd0, data_out}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      check($sformatf("scan row cycle %0d", i), {28'd0, row}, {28'd0, ~(4'b0001 << (i / 4))});
      @(negedge clk);
    end

    for (int v = 0; v < 10; v++)
      commit($sformatf("vec%0d %s", v, vecs[v].seq), vecs[v].seq, vecs[v].exp);

    commit("setup 77", "77#", 11'h04D);
    p0 = pulses;
    enter("8A");
    check("A keeps committed value", {21'd0, data_out[10:0]}, 32'h04D);
    check("A no strobe", pulses - p0, 0);
    commit("hash after A", "#", 11'h000);

    keys = 16'h1 << kpos("7");
    repeat (10) @(negedge clk);
    keys = 16'h0;
    repeat (REL) @(negedge clk);
    commit("glitch rejected", "3#", 11'h003);

    keys = 16'h1 << kpos("8");
    repeat (320) @(negedge clk);
    keys = 16'h0;
    repeat (REL) @(negedge clk);
    commit("long hold one digit", "#", 11'h008);

    keys = (16'h1 << kpos("5")) | (16'h1 << kpos("6"));
    repeat (96) @(negedge clk);
    keys = 16'h1 << kpos("5");
    repeat (96) @(negedge clk);
    keys = 16'h0;
    repeat (REL) @(negedge clk);
    commit("multi-key rejected", "#", 11'h000);
    commit("repress after multi", "5#", 11'h005);

    p0 = pulses;
    sel = 1'b0;
    enter("7#");
    sel = 1'b1;
    check("sel=0 no strobe", pulses - p0, 0);
    check("sel=0 value held", {21'd0, data_out[10:0]}, 32'h005);
    commit("after sel=0 entry empty", "#", 11'h000);

    commit("pre-reset value", "42#", 11'h02A);
    enter("5");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst row", {28'd0, row}, {28'd0, 4'b1110});
    check("rst data_out", {20'd0, data_out}, 32'h0);
    keys = 16'h1 << kpos("#");
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (data_out[11]) break;
    end
    check("post-rst hash strobe", {20'd0, data_out}, 32'h800);
    @(negedge clk);
    check("post-rst strobe drop", {20'd0, data_out}, 32'h000);
    keys = 16'h0;
    repeat (REL) @(negedge clk);

    check("no double-cycle strobe", doubles, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
